// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM request controller: FSM state encoding
// and default address/data/depth parameters.
package sram_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      CAPT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam int ADR_DEF  = 8;
   localparam int DAT_DEF  = 8;
   localparam int DPTH_DEF = 8;

endpackage

// File: rtl/sram_req_ctrl.sv
// Single-request controller in front of a registered-read SRAM.
// Optional range check enabled by SRAM_REQ_CTRL_BOUNDS_CHK_EN.
module sram_req_ctrl
   import sram_pkg::*;
#(
   parameter int ADR  = ADR_DEF,
   parameter int DAT  = DAT_DEF,
   parameter int DPTH = DPTH_DEF
) (
   input  logic           Clk,
   input  logic           Rst,
   input  logic           req_valid,
   input  logic           req_we,
   input  logic [ADR-1:0] req_addr,
   input  logic [DAT-1:0] req_wdata,
   output logic           req_ready,
   output logic           rsp_valid,
   output logic [DAT-1:0] rsp_data,
   output logic           rsp_err,
   input  logic           rsp_ready,
   output logic           sram_cs,
   output logic           sram_we,
   output logic           sram_rd,
   output logic [ADR-1:0] sram_addr,
   output logic [DAT-1:0] sram_din,
   input  logic [DAT-1:0] sram_dout,
   output state_t         dbg_state
);

   // Handshakes: a request transfers on a rising edge with req_valid and
   // req_ready both 1; a response transfers on a rising edge with rsp_valid
   // and rsp_ready both 1. Neither valid may depend on the opposite ready.

   state_t state;
   logic   we_q;

   assign dbg_state = state;

`ifdef SRAM_REQ_CTRL_BOUNDS_CHK_EN
   localparam logic [ADR:0] DPTH_W = (ADR+1)'(DPTH);
   logic oob_q;
   logic err_q;
   logic in_range;

   assign in_range = ({1'b0, req_addr} < DPTH_W);
   assign rsp_err  = err_q;
`else
   assign rsp_err  = 1'b0;
`endif

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         sram_cs   <= 1'b0;
         sram_we   <= 1'b0;
         sram_rd   <= 1'b0;
         sram_addr <= '0;
         sram_din  <= '0;
         we_q      <= 1'b0;
`ifdef SRAM_REQ_CTRL_BOUNDS_CHK_EN
         oob_q     <= 1'b0;
         err_q     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               // req_ready is 1 throughout IDLE, so valid alone means accept
               if (req_valid) begin
                  we_q      <= req_we;
                  sram_addr <= req_addr;
                  sram_din  <= req_wdata;
                  req_ready <= 1'b0;
`ifdef SRAM_REQ_CTRL_BOUNDS_CHK_EN
                  oob_q     <= ~in_range;
                  if (in_range) begin
                     state   <= ISSUE;
                     sram_cs <= 1'b1;
                     sram_we <= req_we;
                     sram_rd <= ~req_we;
                  end else begin
                     state   <= CAPT;
                  end
`else
                  state     <= ISSUE;
                  sram_cs   <= 1'b1;
                  sram_we   <= req_we;
                  sram_rd   <= ~req_we;
`endif
               end
            end
            ISSUE: begin
               sram_cs <= 1'b0;
               sram_we <= 1'b0;
               sram_rd <= 1'b0;
               if (we_q) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
               end else begin
                  state     <= CAPT;
               end
            end
            CAPT: begin
`ifdef SRAM_REQ_CTRL_BOUNDS_CHK_EN
               // Out-of-range writes are dropped silently after one cycle here
               if (oob_q && we_q) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
               end else begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_data  <= oob_q ? '0 : sram_dout;
                  err_q     <= oob_q;
               end
`else
               state     <= RESP;
               rsp_valid <= 1'b1;
               rsp_data  <= sram_dout;
`endif
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Self-checking bench for sram_req_ctrl with a behavioural SRAM and a
// memory-array reference model feeding an expected-response queue.
module tb_sram_req_ctrl;
   import sram_pkg::*;

   localparam int ADR  = 8;
   localparam int DAT  = 8;
   localparam int DPTH = 8;
`ifdef SRAM_REQ_CTRL_BOUNDS_CHK_EN
   localparam bit BOUNDS = 1'b1;
`else
   localparam bit BOUNDS = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic           Clk = 1'b0;
   logic           Rst = 1'b1;
   always #5 Clk = ~Clk;

   logic           req_valid, req_we, req_ready;
   logic [ADR-1:0] req_addr, sram_addr;
   logic [DAT-1:0] req_wdata, rsp_data, sram_din, sram_dout;
   logic           rsp_valid, rsp_err, rsp_ready;
   logic           sram_cs, sram_we, sram_rd;
   state_t         dbg_state;

   sram_req_ctrl #(.ADR(ADR), .DAT(DAT), .DPTH(DPTH)) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .req_valid (req_valid),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .rsp_ready (rsp_ready),
      .sram_cs   (sram_cs),
      .sram_we   (sram_we),
      .sram_rd   (sram_rd),
      .sram_addr (sram_addr),
      .sram_din  (sram_din),
      .sram_dout (sram_dout),
      .dbg_state (dbg_state)
   );

   // Registered-read SRAM covering the full address space
   logic [DAT-1:0] sram_mem [0:255];
   always @(posedge Clk) begin
      if (sram_cs && sram_we) sram_mem[sram_addr] <= sram_din;
      if (sram_cs && sram_rd) sram_dout <= sram_mem[sram_addr];
   end

   // ---------------- reference model / scoreboard ----------------
   logic [DAT-1:0] ref_mem [0:255];
   logic [DAT:0]   exp_q[$];
   logic [DAT:0]   mon_exp;
   int             checks   = 0;
   int             failures = 0;
   int             cs_cnt   = 0;
   bit             rand_rdy = 1'b0;

   function automatic bit out_of_range(input logic [ADR-1:0] a);
      return BOUNDS && (int'(a) >= DPTH);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge Clk) begin
      check("we_rd_exclusive", {31'd0, sram_we & sram_rd}, 32'd0);
      if (!Rst) begin
         if (sram_cs) cs_cnt++;
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_rsp: got data %0h err %0b expected none", rsp_data, rsp_err);
            end else begin
               mon_exp = exp_q.pop_front();
               check("rsp_err_data", {23'd0, rsp_err, rsp_data}, {23'd0, mon_exp});
            end
         end
      end
   end

   // Randomised consumer back-pressure, changed away from the sampling edge
   initial begin
      forever begin
         @(posedge Clk);
         #2;
         if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_req(input logic we, input logic [ADR-1:0] a, input logic [DAT-1:0] d,
                         output time t_acc);
      int n = 0;
      @(negedge Clk);
      while (!req_ready && n < 50) begin
         @(negedge Clk);
         n++;
      end
      if (!req_ready) begin
         checks++;
         failures++;
         $display("FAIL req_ready_timeout: got 0 expected 1");
      end
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      @(posedge Clk);
      t_acc = $time;
      #1;
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_addr  = ADR'($urandom);
      req_wdata = DAT'($urandom);
      if (we) begin
         if (!out_of_range(a)) ref_mem[a] = d;
      end else begin
         exp_q.push_back(out_of_range(a) ? {1'b1, {DAT{1'b0}}} : {1'b0, ref_mem[a]});
      end
   endtask

   task automatic wait_valid(input string name, output int k);
      k = 0;
      do begin
         @(negedge Clk);
         k++;
      end while (!rsp_valid && k < 50);
      if (!rsp_valid) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: got rsp_valid 0 expected 1", name);
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge Clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL %s_drain: got %0d pending expected 0", name, exp_q.size());
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      check({tag, "_rsp_err"},   {31'd0, rsp_err},   32'd0);
      check({tag, "_rsp_data"},  {24'd0, rsp_data},  32'd0);
      check({tag, "_strobes"},   {29'd0, sram_cs, sram_we, sram_rd}, 32'd0);
      check({tag, "_sram_addr"}, {24'd0, sram_addr}, 32'd0);
      check({tag, "_sram_din"},  {24'd0, sram_din},  32'd0);
      check({tag, "_state"},     {30'd0, dbg_state}, {30'd0, IDLE});
   endtask

   // ---------------- main sequence ----------------
   time t0, t1;
   int  lat, cs0;
   logic [ADR-1:0] ra;
   logic [DAT-1:0] rd;

   initial begin
      for (int i = 0; i < 256; i++) begin
         sram_mem[i] = '0;
         ref_mem[i]  = '0;
      end
      sram_dout = '0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b1;
      Rst       = 1'b1;
      repeat (2) @(negedge Clk);
      check_reset_values("reset");
      Rst = 1'b0;

      // Posted write: one-cycle strobe, ready low for one cycle
      do_req(1'b1, 8'd3, 8'hA5, t0);
      @(negedge Clk);
      check("wr_strobes", {29'd0, sram_cs, sram_we, sram_rd}, 32'b110);
      check("wr_addr",    {24'd0, sram_addr}, 32'd3);
      check("wr_din",     {24'd0, sram_din},  32'hA5);
      check("wr_ready_low", {31'd0, req_ready}, 32'd0);
      @(negedge Clk);
      check("wr_strobe_drop", {31'd0, sram_cs}, 32'd0);
      check("wr_ready_back",  {31'd0, req_ready}, 32'd1);

      // Write-to-write spacing
      do_req(1'b1, 8'd1, 8'h11, t0);
      do_req(1'b1, 8'd2, 8'h22, t1);
      check("wr_spacing", 32'((t1 - t0) / 10), 32'd2);

      // Read latency and data
      do_req(1'b0, 8'd3, 8'h00, t0);
      wait_valid("rd_latency", lat);
      check("rd_latency", 32'(lat), 32'd3);
      drain("rd3");

      // Back-to-back read throughput
      do_req(1'b0, 8'd1, 8'h00, t0);
      do_req(1'b0, 8'd2, 8'h00, t1);
      check("rd_spacing", 32'((t1 - t0) / 10), 32'd4);
      drain("rd_b2b");

      // Response held under back-pressure, new requests ignored
      rsp_ready = 1'b0;
      do_req(1'b0, 8'd3, 8'h00, t0);
      wait_valid("hold", lat);
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'b1;
         req_we    = 1'b1;
         req_addr  = 8'd3;
         req_wdata = 8'h5A;
         check("hold_valid", {31'd0, rsp_valid}, 32'd1);
         check("hold_data",  {24'd0, rsp_data},  {24'd0, ref_mem[3]});
         check("hold_ready", {31'd0, req_ready}, 32'd0);
         @(negedge Clk);
      end
      @(posedge Clk);
      #1;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      drain("hold");
      do_req(1'b0, 8'd3, 8'h00, t0);
      drain("hold_readback");

      // Reset during ISSUE drops the strobe without waiting for a clock
      do_req(1'b0, 8'd2, 8'h00, t0);
      @(negedge Clk);
      check("issue_cs", {31'd0, sram_cs}, 32'd1);
      Rst = 1'b1;
      #1;
      check("issue_rst_cs", {29'd0, sram_cs, sram_we, sram_rd}, 32'd0);
      exp_q.delete();
      @(negedge Clk);
      Rst = 1'b0;

      // Reset during CAPT aborts the read
      do_req(1'b0, 8'd1, 8'h00, t0);
      repeat (2) @(negedge Clk);
      Rst = 1'b1;
      #1;
      check_reset_values("capt_rst");
      exp_q.delete();
      @(negedge Clk);
      Rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk);
         check("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      end
      do_req(1'b0, 8'd2, 8'h00, t0);
      drain("post_rst_read");

      // Address beyond DPTH: range-checked or passed through
      cs0 = cs_cnt;
      do_req(1'b1, 8'd9, 8'h9C, t0);
      repeat (3) @(negedge Clk);
      check("oob_wr_strobe", 32'(cs_cnt - cs0), BOUNDS ? 32'd0 : 32'd1);
      check("oob_wr_mem", {24'd0, sram_mem[9]}, {24'd0, ref_mem[9]});
      cs0 = cs_cnt;
      do_req(1'b0, 8'd9, 8'h00, t0);
      drain("oob_rd");
      check("oob_rd_strobe", 32'(cs_cnt - cs0), BOUNDS ? 32'd0 : 32'd1);

      // Random alternating write/read over the in-range space
      rand_rdy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         ra = ADR'($urandom_range(0, DPTH - 1));
         rd = DAT'($urandom);
         do_req(1'b1, ra, rd, t0);
         ra = ADR'($urandom_range(0, DPTH - 1));
         do_req(1'b0, ra, 8'h00, t0);
      end
      drain("random");
      rand_rdy = 1'b0;
      repeat (3) @(negedge Clk);
      for (int a = 0; a < DPTH; a++)
         check("final_mem", {24'd0, sram_mem[a]}, {24'd0, ref_mem[a]});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sram_req_ctrl.md
SRAM_REQ_CTRL -- requirements
Module: sram_req_ctrl

Interface
REQ-001 Parameters SHALL be ADR, default 8, address width; DAT, default 8, data width; DPTH, default 8, number of words in the downstream SRAM.
REQ-002 Clk  input  1  single clock; all state changes on rising edge.
REQ-003 Rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  request present; req_we  input  1  1=write, 0=read; req_addr  input  ADR  word address; req_wdata  input  DAT  write data.
REQ-005 req_ready  output  1  controller can accept a request.
REQ-006 rsp_valid  output  1  read data valid; rsp_data  output  DAT  read data; rsp_err  output  1  out-of-range flag (macro only, else tied 0); rsp_ready  input  1  consumer accepts response.
REQ-007 sram_cs, sram_we, sram_rd  output  1 each; sram_addr  output  ADR; sram_din  output  DAT; sram_dout  input  DAT  (registered SRAM read port).

Function
REQ-008 FSM states SHALL be IDLE, ISSUE, CAPT, RESP.
REQ-009 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1, latching req_we/req_addr/req_wdata.
REQ-010 IDLE->ISSUE on accept; otherwise IDLE holds.
REQ-011 In ISSUE, sram_cs=1 and exactly one of sram_we (write) or sram_rd (read) SHALL be 1, sram_addr/sram_din from latched values, for exactly one cycle.
REQ-012 Outside ISSUE, sram_cs, sram_we, sram_rd SHALL be 0; sram_we and sram_rd SHALL never both be 1.
REQ-013 Write: ISSUE->IDLE; writes are posted, no response; a new request can be accepted 2 cycles after the previous accept.
REQ-014 Read: ISSUE->CAPT->RESP; at the edge leaving CAPT, rsp_data SHALL capture sram_dout.
REQ-015 In RESP rsp_valid=1 with rsp_data stable; RESP->IDLE on the edge with rsp_ready=1; otherwise hold.
REQ-016 Read latency: rsp_valid asserts 3 cycles after accept edge; with rsp_ready held 1, back-to-back read throughput SHALL be one per 4 cycles.
REQ-017 rsp_data SHALL retain last read value after RESP until the next CAPT.
REQ-018 req_valid may drop or inputs change while not in IDLE with no effect on the in-flight operation.

Reset
REQ-019 Rst=1 SHALL immediately force state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0, sram_cs/we/rd=0, sram_addr=0, sram_din=0.
REQ-020 Reset during ISSUE/CAPT/RESP SHALL abort the operation, with no response after reset release; the SRAM strobe SHALL drop asynchronously.

Configuration
REQ-021 Macro SRAM_REQ_CTRL_BOUNDS_CHK_EN defined: a request with req_addr >= DPTH SHALL be accepted but skip ISSUE (no SRAM strobe); a read goes IDLE->CAPT->RESP with rsp_err=1, rsp_data=0; a write returns to IDLE after one cycle in CAPT, no response.
REQ-022 Macro undefined: no range check; rsp_err tied 0; upper addresses pass to SRAM unchanged.

Structure
REQ-023 A shared package sram_pkg SHALL hold the FSM state enum and default ADR/DAT/DPTH constants.
REQ-024 No sub-module; the SRAM itself is instantiated beside this block, not inside it.

Verification
REQ-025 Reset released, write addr 3 data 0xA5 -> sram_cs=1, sram_we=1, sram_addr=3, sram_din=0xA5 for exactly one cycle, req_ready low one cycle.
REQ-026 After REQ-025, read addr 3 with rsp_ready=1 -> rsp_valid high 3 cycles after accept, rsp_data=0xA5, rsp_err=0.
REQ-027 Read addr 3 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data=0xA5 held, req_ready=0 throughout; new req_valid ignored until rsp_ready=1.
REQ-028 Rst pulsed during CAPT of a read -> all outputs at reset values immediately, no rsp_valid afterwards, next read completes normally.
REQ-029 Macro defined, DPTH=8, read addr 9 -> no SRAM strobe, rsp_valid with rsp_err=1, rsp_data=0; write addr 9 -> no sram_we, memory unchanged.
REQ-030 Alternating write/read to addrs 0..7 with random data -> every read matches last written value; sram_we and sram_rd never simultaneously 1.
